// File: rtl/an3_serial_encoder.sv
// an3_serial_encoder: bit-serial AN-code (A=3) transmitter.
// A captured word N is multiplied by 3 LSB-first as N + 2N using a one-bit
// carry, then the codeword is streamed MSB-first with start/end flags.
// Every emitted frame is divisible by 3.
module an3_serial_encoder #(
    parameter int W  = 8,
    parameter int CW = W + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ser_out,
    output logic          ser_valid,
    input  logic          ser_ready,
    output logic          ser_first,
    output logic          ser_last,
    output logic          busy,
    output logic [CW-1:0] code_out
);

    localparam int            KW     = $clog2(CW);
    localparam logic [KW-1:0] K_LAST = KW'(CW - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [W-1:0]  r_n;      // captured data word
    logic [KW-1:0] r_k;      // multiply bit index, LSB first
    logic [KW-1:0] r_j;      // serial bit index, MSB first
    logic          r_carry;  // two-state carry of the add-with-carry
    logic [CW-2:0] r_c;      // product bits collected so far, shifted in at the top
    logic [CW-1:0] r_sh;     // output shift register, MSB is the current bit
    logic [CW-1:0] r_code;   // parallel copy of the last finished codeword

    logic [CW-1:0] w_n_ext;  // N zero-extended: position k holds N[k]
    logic [CW-1:0] w_n_dly;  // 2N: position k holds N[k-1], N[-1] = 0
    logic [1:0]    w_sum;    // N[k] + N[k-1] + carry, never exceeds 3

    assign w_n_ext = CW'(r_n);
    assign w_n_dly = CW'({r_n, 1'b0});
    assign w_sum   = {1'b0, w_n_ext[r_k]} + {1'b0, w_n_dly[r_k]} + {1'b0, r_carry};

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept in IDLE, CW multiply steps, CW accepted beats.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)                  w_state_next = S_MUL;
            S_MUL:   if (r_k == K_LAST)             w_state_next = S_SHIFT;
            S_SHIFT: if (ser_ready && r_j == '0)    w_state_next = S_IDLE;
            default:                                w_state_next = S_IDLE;
        endcase
    end

    // Output decode; flags are only meaningful while a bit is offered.
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        ser_valid = (r_state == S_SHIFT);
        ser_out   = ser_valid & r_sh[CW-1];
        ser_first = ser_valid & (r_j == K_LAST);
        ser_last  = ser_valid & (r_j == '0);
        code_out  = r_code;
    end

    // Datapath: capture, bit-serial multiply by 3, then MSB-first shift-out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n     <= '0;
            r_k     <= '0;
            r_j     <= '0;
            r_carry <= 1'b0;
            r_c     <= '0;
            r_sh    <= '0;
            r_code  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_n     <= in_data;
                        r_k     <= '0;
                        r_carry <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_carry <= w_sum[1];
                    r_k     <= r_k + 1'b1;
                    r_c     <= {w_sum[0], r_c[CW-2:1]};
                    if (r_k == K_LAST) begin
                        // r_c already holds C[CW-2:0]; this step supplies C[CW-1].
                        r_sh   <= {w_sum[0], r_c};
                        r_code <= {w_sum[0], r_c};
                        r_j    <= K_LAST;
                    end
                end
                S_SHIFT: begin
                    if (ser_ready) begin
                        r_sh <= {r_sh[CW-2:0], 1'b0};
                        r_j  <= r_j - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // 3*N fits in CW bits, so the carry out of the top position is always 0.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_MUL && r_k == K_LAST) begin
            assert (w_sum[1] == 1'b0);
        end
    end

endmodule

// File: tb/tb_an3_serial_encoder.sv
// tb_an3_serial_encoder: directed checks of the AN3 serial encoder.
module tb_an3_serial_encoder;

    localparam int W  = 8;
    localparam int CW = W + 2;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_ready;
    logic          ser_first;
    logic          ser_last;
    logic          busy;
    logic [CW-1:0] code_out;

    int n_vec = 0;
    int n_err = 0;

    an3_serial_encoder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy),
        .code_out  (code_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word until accepted. On return the bench sits in cycle 1
    // (the accept edge is cycle 0). keep_valid leaves in_valid asserted.
    task automatic send_word(input logic [W-1:0] n, input bit keep_valid, output bit tmo);
        int waited;
        waited = 0;
        tmo = 1'b0;
        in_data  = n;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) tmo = 1'b1;
        tick();
        if (!keep_valid) in_valid = 1'b0;
    endtask

    // Collect one frame starting in cycle 1. With bp set, ser_ready is 1 in
    // the accept cycle and toggles every cycle after that. Returns the frame
    // value, the cycle of the first valid bit, the number of valid cycles,
    // flag / stall-stability error counts and the cycle reached afterwards.
    task automatic recv_frame(input bit bp, output logic [CW-1:0] val, output int first_cyc,
                              output int valid_cyc, output int flag_err, output int stall_err,
                              output int end_cyc, output bit tmo);
        int   beat;
        int   cyc;
        bit   pend;
        logic [2:0] held;
        beat = 0; cyc = 1; pend = 1'b0; held = '0;
        val = '0; first_cyc = -1; valid_cyc = 0; flag_err = 0; stall_err = 0; tmo = 1'b0;
        while (beat < CW) begin
            if (cyc > 200) begin
                tmo = 1'b1;
                break;
            end
            ser_ready = bp ? (cyc % 2 == 0) : 1'b1;
            if (pend && {ser_out, ser_first, ser_last} !== held) stall_err++;
            pend = 1'b0;
            if (ser_valid === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                valid_cyc++;
                if (ser_first !== (beat == 0) || ser_last !== (beat == CW - 1)) flag_err++;
                if (ser_ready) begin
                    val = {val[CW-2:0], ser_out};
                    beat++;
                end else begin
                    pend = 1'b1;
                    held = {ser_out, ser_first, ser_last};
                end
            end else if (ser_first !== 1'b0 || ser_last !== 1'b0) begin
                flag_err++;
            end
            tick();
            cyc++;
        end
        ser_ready = 1'b1;
        end_cyc = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_vec++; if (ser_valid !== 1'b0) begin n_err++; $display("FAIL reset_ser_valid: got %b want 0", ser_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (code_out !== '0) begin n_err++; $display("FAIL reset_code_out: got %0d want 0", code_out); end
        n_vec++; if ({ser_out, ser_first, ser_last} !== 3'b000) begin n_err++; $display("FAIL reset_ser_bits: got %b want 000", {ser_out, ser_first, ser_last}); end
        rst = 1'b0;
        tick();
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        $display("reset: in_ready=%b busy=%b code_out=%0d", in_ready, busy, code_out);
    endtask

    // Unstalled frame: value, flags, latency and in_ready return.
    task automatic run_plain(input string name, input logic [W-1:0] n, input logic [CW-1:0] exp_code);
        logic [CW-1:0] val;
        int fc, vc, fe, se, ec;
        bit t1, t2;
        send_word(n, 1'b0, t1);
        n_vec++; if (t1 || busy !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL %s_accept: tmo=%b busy=%b in_ready=%b want 0 1 0", name, t1, busy, in_ready); end
        recv_frame(1'b0, val, fc, vc, fe, se, ec, t2);
        n_vec++; if (t2 || val !== exp_code) begin n_err++; $display("FAIL %s_stream: got %b want %b", name, val, exp_code); end
        n_vec++; if (fc !== CW + 1) begin n_err++; $display("FAIL %s_first_cycle: got %0d want %0d", name, fc, CW + 1); end
        n_vec++; if (fe !== 0) begin n_err++; $display("FAIL %s_flags: got %0d flag errors want 0", name, fe); end
        n_vec++; if (code_out !== exp_code) begin n_err++; $display("FAIL %s_code_out: got %0d want %0d", name, code_out, exp_code); end
        n_vec++; if (ec !== 2 * CW + 1 || in_ready !== 1'b1 || ser_valid !== 1'b0) begin n_err++; $display("FAIL %s_return: cycle %0d in_ready=%b ser_valid=%b want %0d 1 0", name, ec, in_ready, ser_valid, 2 * CW + 1); end
        $display("%s: N=%0d stream=%b code_out=%0d", name, n, val, code_out);
    endtask

    task automatic test_basic();
        run_plain("basic", 8'h29, 10'b0001111011);
    endtask

    task automatic test_max();
        run_plain("max", 8'hFF, 10'b1011111101);
    endtask

    task automatic test_zero();
        run_plain("zero", 8'h00, 10'b0000000000);
    endtask

    task automatic test_backpressure();
        logic [CW-1:0] val;
        int fc, vc, fe, se, ec;
        bit t1, t2;
        send_word(8'hAA, 1'b0, t1);
        recv_frame(1'b1, val, fc, vc, fe, se, ec, t2);
        n_vec++; if (t1 || t2 || val !== 10'b0111111110) begin n_err++; $display("FAIL bp_stream: got %b want 0111111110", val); end
        n_vec++; if (se !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d changes want 0", se); end
        n_vec++; if (vc !== 2 * CW) begin n_err++; $display("FAIL bp_span: got %0d cycles want %0d", vc, 2 * CW); end
        n_vec++; if (fe !== 0) begin n_err++; $display("FAIL bp_flags: got %0d flag errors want 0", fe); end
        $display("backpressure: N=170 stream=%b span=%0d", val, vc);
    endtask

    task automatic test_busy_collision();
        logic [CW-1:0] val;
        int fc, vc, fe, se, ec;
        bit t1, t2;
        send_word(8'h05, 1'b1, t1);
        in_data = 8'h07;
        recv_frame(1'b0, val, fc, vc, fe, se, ec, t2);
        n_vec++; if (t1 || t2 || val !== 10'b0000001111) begin n_err++; $display("FAIL coll_first: got %b want 0000001111", val); end
        n_vec++; if (in_ready !== 1'b1 || ec !== 2 * CW + 1) begin n_err++; $display("FAIL coll_ready: in_ready=%b cycle %0d want 1 %0d", in_ready, ec, 2 * CW + 1); end
        tick();
        in_valid = 1'b0;
        recv_frame(1'b0, val, fc, vc, fe, se, ec, t2);
        n_vec++; if (t2 || val !== 10'b0000010101 || code_out !== 10'd21) begin n_err++; $display("FAIL coll_second: got %b code_out %0d want 0000010101 21", val, code_out); end
        $display("busy_collision: second stream=%b", val);
    endtask

    task automatic test_reset_mid_shift();
        logic [CW-1:0] val;
        int fc, vc, fe, se, ec, waited;
        bit t1, t2;
        send_word(8'h29, 1'b0, t1);
        ser_ready = 1'b1;
        waited = 0;
        while (ser_valid !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        n_vec++; if (t1 || ser_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_start: ser_valid=%b want 1", ser_valid); end
        for (int b = 0; b < 4; b++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (ser_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_abort: ser_valid=%b busy=%b want 0 0", ser_valid, busy); end
        n_vec++; if (code_out !== '0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_state: code_out=%0d in_ready=%b want 0 1", code_out, in_ready); end
        send_word(8'h33, 1'b0, t1);
        recv_frame(1'b0, val, fc, vc, fe, se, ec, t2);
        n_vec++; if (t1 || t2 || val !== 10'd153) begin n_err++; $display("FAIL rst_mid_recover: got %0d want 153", val); end
        $display("reset_mid_shift: recovered stream=%0d", val);
    endtask

    task automatic test_exhaustive();
        logic [CW-1:0] val;
        int fc, vc, fe, se, ec;
        bit t1, t2;
        for (int n = 0; n < 256; n++) begin
            send_word(W'(n), 1'b0, t1);
            recv_frame(1'b0, val, fc, vc, fe, se, ec, t2);
            n_vec++; if (t1 || t2 || (int'(val) % 3) != 0) begin n_err++; $display("FAIL exh_mod3 N=%0d: got %0d remainder %0d want 0", n, val, int'(val) % 3); end
            n_vec++; if (int'(val) / 3 != n) begin n_err++; $display("FAIL exh_value N=%0d: got %0d/3=%0d want %0d", n, val, int'(val) / 3, n); end
            $display("exhaustive: N=%0d code=%0d", n, val);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_busy_collision();
        test_reset_mid_shift();
        test_exhaustive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
